// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle control FSM for the 16-bit RISC core: sequences fetch/decode/execute/memory/writeback.
// Optional performance counters are enabled by defining ALU_CTRL_PERF_CNT_EN.
module alu_ctrl_fsm #(
    parameter int IMM6_W = 6,
    parameter int IMM9_W = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    output logic        ir_we,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        alu_zero,
    input  logic        alu_carry,
    output logic [1:0]  alu_op,
    output logic        alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic        pc_we,
    output logic        rf_we,
    output logic [1:0]  rf_waddr_sel,
    output logic [1:0]  rf_wdata_sel,
    output logic        z_flag,
    output logic        c_flag,
    output logic        halted,
    output logic        illegal
`ifdef ALU_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_BR,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;

    localparam logic [1:0] B_RF    = 2'b00;
    localparam logic [1:0] B_ONE   = 2'b01;
    localparam logic [1:0] B_IMM6  = 2'b10;
    localparam logic [1:0] B_IMM9  = 2'b11;

    state_e state_q, state_d;
    logic   z_q, z_d;
    logic   c_q, c_d;

    logic [3:0] opcode;
    logic       is_alu, is_adi, is_lw, is_sw, is_beq, is_jal, is_halt;

    // Immediate fields are consumed by the datapath, not by this controller.
    logic unused_imm_fields;
    assign unused_imm_fields = ^{ir[11:IMM9_W], ir[IMM9_W-1:IMM6_W], ir[IMM6_W-1:0]};

    assign opcode  = ir[15:12];
    assign is_alu  = (opcode[3:2] == 2'b00);
    assign is_adi  = (opcode == 4'b0100);
    assign is_lw   = (opcode == 4'b0101);
    assign is_sw   = (opcode == 4'b0110);
    assign is_beq  = (opcode == 4'b0111);
    assign is_jal  = (opcode == 4'b1000);
    assign is_halt = (opcode == 4'b1111);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= S_FETCH;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d      = state_q;
        z_d          = z_q;
        c_d          = c_q;
        ir_we        = 1'b0;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        alu_op       = OP_ADD;
        alu_a_sel    = 1'b0;
        alu_b_sel    = B_RF;
        pc_we        = 1'b0;
        rf_we        = 1'b0;
        rf_waddr_sel = 2'b00;
        rf_wdata_sel = 2'b00;
        halted       = 1'b0;
        illegal      = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we     = 1'b1;
                    alu_a_sel = 1'b1;
                    alu_b_sel = B_ONE;
                    pc_we     = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (is_alu || is_adi) begin
                    alu_op    = is_alu ? ir[13:12] : OP_ADD;
                    alu_b_sel = is_alu ? B_RF : B_IMM6;
                    z_d       = alu_zero;
                    c_d       = alu_carry;
                    state_d   = S_WB;
                end else if (is_lw || is_sw) begin
                    alu_b_sel = B_IMM6;
                    state_d   = S_MEM;
                end else if (is_beq) begin
                    alu_op    = OP_SUB;
                    state_d   = alu_zero ? S_BR : S_FETCH;
                end else if (is_jal) begin
                    // PC already holds PC+1 from fetch; that is the link value.
                    rf_we        = 1'b1;
                    rf_waddr_sel = 2'b10;
                    rf_wdata_sel = 2'b10;
                    alu_a_sel    = 1'b1;
                    alu_b_sel    = B_IMM9;
                    pc_we        = 1'b1;
                    state_d      = S_FETCH;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_BR: begin
                alu_a_sel = 1'b1;
                alu_b_sel = B_IMM6;
                pc_we     = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                if (dmem_ack) state_d = is_sw ? S_FETCH : S_WB;
            end
            S_WB: begin
                rf_we        = 1'b1;
                rf_waddr_sel = is_alu ? 2'b00 : 2'b01;
                rf_wdata_sel = is_lw ? 2'b01 : 2'b00;
                state_d      = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_FETCH;
        endcase

        // Reset must silence every enable and request in the same cycle.
        if (rst) begin
            ir_we    = 1'b0;
            imem_req = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            pc_we    = 1'b0;
            rf_we    = 1'b0;
            halted   = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign z_flag = z_q;
    assign c_flag = c_q;

`ifdef ALU_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] instr_cnt_q;
    logic        instr_done;

    assign instr_done = (state_q inside {S_EXEC, S_BR, S_MEM, S_WB}) && (state_d == S_FETCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != S_HALT && cycle_cnt_q != '1) cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (instr_done && instr_cnt_q != '1)        instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed bench for alu_ctrl_fsm: walks each instruction class cycle by cycle
// against hand-derived control values, then exercises HALT and reset mid-access.
module tb_alu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic        ir_we, imem_req, imem_ack;
    logic        dmem_req, dmem_we, dmem_ack;
    logic        alu_zero, alu_carry;
    logic [1:0]  alu_op;
    logic        alu_a_sel;
    logic [1:0]  alu_b_sel;
    logic        pc_we, rf_we;
    logic [1:0]  rf_waddr_sel, rf_wdata_sel;
    logic        z_flag, c_flag, halted, illegal;

    int n_checks = 0;
    int n_pass   = 0;

    alu_ctrl_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .ir           (ir),
        .ir_we        (ir_we),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ack     (dmem_ack),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_op       (alu_op),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .pc_we        (pc_we),
        .rf_we        (rf_we),
        .rf_waddr_sel (rf_waddr_sel),
        .rf_wdata_sel (rf_wdata_sel),
        .z_flag       (z_flag),
        .c_flag       (c_flag),
        .halted       (halted),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    // Enables/requests packed for compact "all quiet" checks.
    function automatic logic [6:0] en_vec();
        return {imem_req, ir_we, pc_we, rf_we, dmem_req, illegal, halted};
    endfunction

    initial begin
        int held;
        int bad;
        rst = 1'b1; ir = 16'h0000; imem_ack = 1'b1; dmem_ack = 1'b1;
        alu_zero = 1'b0; alu_carry = 1'b0;

        // Reset: outputs quiet even though FETCH sees imem_ack high.
        @(negedge clk); #1;
        check("reset_enables", en_vec(), 7'd0);
        check("reset_flags", {z_flag, c_flag}, 2'b00);

        // ADD r3 = r1 + r2
        @(negedge clk); rst = 1'b0; ir = 16'h0298; #1;
        check("add_fetch_req", {imem_req, ir_we, pc_we}, 3'b111);
        check("add_fetch_pcinc", {alu_a_sel, alu_b_sel, alu_op}, {1'b1, 2'b01, 2'b00});
        @(negedge clk); #1;
        check("add_decode_quiet", en_vec(), 7'd0);
        @(negedge clk); #1;
        check("add_exec", {alu_op, alu_b_sel, rf_we, pc_we}, {2'b00, 2'b00, 1'b0, 1'b0});
        @(negedge clk); #1;
        check("add_wb", {rf_we, rf_waddr_sel, rf_wdata_sel}, {1'b1, 2'b00, 2'b00});

        // SUB sets Z=1, C=0
        @(negedge clk); ir = 16'h1298; #1;
        check("add_lat4_fetch", imem_req, 1'b1);
        @(negedge clk);
        @(negedge clk); alu_zero = 1'b1; alu_carry = 1'b0; #1;
        check("sub_exec_op", alu_op, 2'b01);
        @(negedge clk); alu_zero = 1'b0; alu_carry = 1'b1; #1;
        check("sub_flags", {z_flag, c_flag}, 2'b10);

        // LW with dmem_ack delayed 3 cycles
        @(negedge clk); ir = 16'h5285; dmem_ack = 1'b0; #1;
        check("lw_fetch", imem_req, 1'b1);
        @(negedge clk);
        @(negedge clk); #1;
        check("lw_exec", {alu_op, alu_b_sel, rf_we}, {2'b00, 2'b10, 1'b0});
        held = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); dmem_ack = (i == 3); #1;
            if (dmem_req && !dmem_we) held++;
        end
        check("lw_mem_hold4", held, 4);
        @(negedge clk); dmem_ack = 1'b1; #1;
        check("lw_wb", {rf_we, rf_waddr_sel, rf_wdata_sel, dmem_req}, {1'b1, 2'b01, 2'b01, 1'b0});
        check("lw_flags_kept", {z_flag, c_flag}, 2'b10);

        // SW zero-wait: 4 cycles
        @(negedge clk); ir = 16'h6285; #1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); #1;
        check("sw_mem", {dmem_req, dmem_we}, 2'b11);

        // BEQ taken
        @(negedge clk); ir = 16'h7285; #1;
        check("sw_lat4_fetch", imem_req, 1'b1);
        @(negedge clk);
        @(negedge clk); alu_zero = 1'b1; alu_carry = 1'b1; #1;
        check("beq_t_exec", {alu_op, alu_b_sel, pc_we}, {2'b01, 2'b00, 1'b0});
        @(negedge clk); alu_zero = 1'b0; alu_carry = 1'b0; #1;
        check("beq_br", {pc_we, alu_a_sel, alu_b_sel, alu_op}, {1'b1, 1'b1, 2'b10, 2'b00});
        check("beq_flags_kept", {z_flag, c_flag}, 2'b10);

        // BEQ not taken
        @(negedge clk); #1;
        check("beq_t_lat4_fetch", imem_req, 1'b1);
        @(negedge clk);
        @(negedge clk); #1;
        check("beq_nt_exec_nopc", pc_we, 1'b0);
        @(negedge clk); ir = 16'h8005; #1;
        check("beq_nt_fetch", imem_req, 1'b1);

        // JAL
        @(negedge clk);
        @(negedge clk); #1;
        check("jal_exec_rf", {rf_we, rf_waddr_sel, rf_wdata_sel}, {1'b1, 2'b10, 2'b10});
        check("jal_exec_pc", {pc_we, alu_a_sel, alu_b_sel, alu_op}, {1'b1, 1'b1, 2'b11, 2'b00});

        // Illegal opcode 1010
        @(negedge clk); ir = 16'hA000; #1;
        check("jal_lat3_fetch", imem_req, 1'b1);
        @(negedge clk);
        @(negedge clk); #1;
        check("illegal_pulse", {illegal, rf_we, pc_we}, 3'b100);
        @(negedge clk); ir = 16'hF000; #1;
        check("illegal_one_cycle", {illegal, imem_req}, 2'b01);

        // HALT: sticky for 100 cycles, no fetches
        @(negedge clk);
        @(negedge clk); #1;
        check("halt_exec_not_yet", halted, 1'b0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (!halted || imem_req) bad++;
        end
        check("halt_100_cycles", bad, 0);

        // Leave HALT via reset; set both flags with an ADD
        @(negedge clk); rst = 1'b1; #1;
        check("rst_halted_clear", halted, 1'b0);
        @(negedge clk); rst = 1'b0; ir = 16'h0000; #1;
        check("rst_fetch_again", imem_req, 1'b1);
        @(negedge clk);
        @(negedge clk); alu_zero = 1'b1; alu_carry = 1'b1;
        @(negedge clk); alu_zero = 1'b0; alu_carry = 1'b0; #1;
        check("add_flags_11", {z_flag, c_flag}, 2'b11);

        // Reset during a MEM wait
        @(negedge clk); ir = 16'h5000; dmem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); #1;
        check("mem_wait_req", dmem_req, 1'b1);
        @(negedge clk); rst = 1'b1; #1;
        check("rst_dmem_immediate", dmem_req, 1'b0);
        @(negedge clk); #1;
        check("rst_mid_mem_quiet", {en_vec(), z_flag, c_flag}, 9'd0);
        rst = 1'b0; #1;
        check("rst_mid_mem_fetch", {imem_req, dmem_req}, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
Multi-cycle control unit for the 16-bit RISC core. It fetches one instruction at a time and sequences the shared 2-bit-op ALU (ADD/SUB/CMP/NAND) through its phases: PC increment, execute, branch target and address generation. It drives the datapath mux selects, write enables and memory request/acknowledge handshakes, and holds the architectural zero and carry flags.

Parameters:
IMM6_W, 6, width of the short immediate field instr[5:0], sign-extended by the datapath
IMM9_W, 9, width of the jump immediate field instr[8:0], sign-extended by the datapath

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
ir  in  16  current instruction register contents
ir_we  out  1  latch imem_rdata into the IR
imem_req  out  1  instruction fetch request
imem_ack  in  1  fetch data valid; may be high in the same cycle as imem_req
dmem_req  out  1  data memory request
dmem_we  out  1  1 = store, 0 = load; valid only while dmem_req is high
dmem_ack  in  1  data access complete
alu_zero  in  1  zero output of the ALU
alu_carry  in  1  carry/borrow output of the ALU
alu_op  out  2  00 ADD, 01 SUB, 10 CMP, 11 NAND
alu_a_sel  out  1  0 = register-file port A, 1 = PC
alu_b_sel  out  2  00 = RF port B, 01 = constant 1, 10 = sext imm6, 11 = sext imm9
pc_we  out  1  PC <= ALU result
rf_we  out  1  register-file write enable
rf_waddr_sel  out  2  00 = ir[5:3], 01 = ir[8:6], 10 = ir[11:9]
rf_wdata_sel  out  2  00 = ALU-out register, 01 = dmem read data, 10 = PC
z_flag  out  1  architectural zero flag
c_flag  out  1  architectural carry flag
halted  out  1  processor halted
illegal  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset: state <= FETCH; z_flag, c_flag, halted, illegal <= 0. Every enable and request output is forced to 0 while rst is high. Reset asserted in any state, including a pending memory wait, aborts the operation.
- Decode: opcode = ir[15:12].
  - 0000 ADD, 0001 SUB, 0010 CMP, 0011 NAND: rc <= ra op rb.
  - 0100 ADI: rb <= ra + imm6.
  - 0101 LW: rb <= M[ra + imm6].
  - 0110 SW: M[ra + imm6] <= rb.
  - 0111 BEQ: PC <= PC + imm6 if ra == rb.
  - 1000 JAL: ra <= PC; PC <= PC + imm9.
  - 1111 HALT.
  - Any other opcode is illegal.
- Datapath contract: the ALU-out register captures the ALU result every cycle.
- FETCH:
  - Assert imem_req. Stay in FETCH until imem_ack is high.
  - In the ack cycle: ir_we = 1, alu_a_sel = 1, alu_b_sel = 01, alu_op = 00, pc_we = 1. Then go to DECODE.
- DECODE: one cycle for register-file read. No enables asserted. Go to EXEC.
- EXEC, ALU ops and ADI:
  - alu_op = ir[13:12] for ALU ops, 00 for ADI. alu_b_sel = 00 for ALU ops, 10 for ADI.
  - z_flag <= alu_zero and c_flag <= alu_carry. Go to WB.
- EXEC, LW/SW: alu_op = 00, alu_b_sel = 10. Go to MEM. Flags are unchanged.
- EXEC, BEQ: alu_op = 01, alu_b_sel = 00. If alu_zero, go to BR; otherwise go to FETCH. Flags are unchanged.
- EXEC, JAL:
  - rf_we = 1, rf_waddr_sel = 10, rf_wdata_sel = 10. The PC written is the already-incremented value.
  - alu_a_sel = 1, alu_b_sel = 11, alu_op = 00, pc_we = 1. Go to FETCH.
- EXEC, HALT: go to HALT.
- EXEC, illegal opcode: illegal = 1 for this cycle; executes as a NOP. Go to FETCH.
- BR: alu_a_sel = 1, alu_b_sel = 10, alu_op = 00, pc_we = 1. Go to FETCH.
- MEM:
  - Assert dmem_req, with dmem_we = 1 for SW. Hold until dmem_ack.
  - On ack: SW goes to FETCH; LW goes to WB.
- WB: rf_we = 1.
  - rf_waddr_sel = 00 for R-type, 01 for ADI/LW.
  - rf_wdata_sel = 01 for LW, otherwise 00.
  - Go to FETCH.
- HALT: halted = 1, no requests. Only rst exits this state.
- Latency with zero-wait acks:
  - R-type/ADI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles not taken, 4 taken.
  - JAL: 3 cycles.
- PC arithmetic is 16-bit modulo; 0xFFFF + 1 wraps to 0x0000 without fault.
- Acks arriving in any state other than the one waiting for them are ignored.

Optional Feature:
Macro ALU_CTRL_PERF_CNT_EN.
- When defined, adds outputs cycle_cnt[31:0] and instr_cnt[31:0].
  - cycle_cnt increments every cycle when not halted and not in reset.
  - instr_cnt increments on every transition into FETCH from EXEC, BR, MEM or WB.
  - Both reset to 0 and saturate at 0xFFFFFFFF.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- ADD r3 = r1 + r2 (ir = 0x0298), acks tied high -> imem_req, DECODE, EXEC with alu_op = 00, then WB with rf_we = 1 and rf_waddr_sel = 00; PC advances by 1; 4 cycles total.
- SUB with alu_zero = 1 and alu_carry = 0 in EXEC -> z_flag = 1 and c_flag = 0 from the next cycle; a following LW leaves both flags unchanged.
- LW with dmem_ack delayed 3 cycles -> dmem_req held for 4 cycles with dmem_we = 0; then WB with rf_wdata_sel = 01 and rf_waddr_sel = 01.
- BEQ with alu_zero = 1 -> BR state asserts pc_we with alu_b_sel = 10. With alu_zero = 0 -> back in FETCH after EXEC, and no pc_we during EXEC.
- Opcode 1010 -> illegal pulses for exactly 1 cycle and no rf_we/pc_we. A subsequent HALT (0xF000) -> halted = 1 and stays high for 100 cycles with imem_req = 0.
- rst asserted during a MEM wait -> next state FETCH, dmem_req = 0 immediately, flags = 0, halted = 0.
